// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and multi-cycle mul/div occupancy of EX.
// Latency: zero -- all controls are Mealy (current state + current inputs) and act on the buffers at the next edge.
// Backpressure: stalls the front end through PC_WRITE/IFID_WRITE=0; holds EX via IDEX_HOLD and fills MEM via EXMEM_BUBBLE.
//
// Ports:
//   clk, rst                     clock; synchronous active-low reset
//   IDEX_MemRead/RT/opcode       EX-stage instruction info (load flag, destination, opcode)
//   IFID_RS, IFID_RT             ID-stage source registers
//   branch_taken                 branch in EX resolved taken this cycle
//   clr_cnt                      synchronous clear of the performance counters
//   PC_WRITE, IFID_WRITE         front-end advance enables
//   IFID_FLUSH, IDEX_FLUSH       load NOP / bubble into the stage buffers
//   IDEX_HOLD, EXMEM_BUBBLE      keep mul/div in EX, feed zero controls to MEM
//   busy                         multi-cycle sequence in progress
//   stall_cnt, flush_cnt         saturating performance counters
module pipe_hazard_ctrl #(
  parameter int unsigned MULDIV_CYCLES = 4,
  parameter logic [3:0]  MULDIV_OPCODE = 4'hE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IDEX_MemRead,
  input  logic [3:0]  IDEX_RT,
  input  logic [3:0]  IDEX_opcode,
  input  logic [3:0]  IFID_RS,
  input  logic [3:0]  IFID_RT,
  input  logic        branch_taken,
  input  logic        clr_cnt,
  output logic        PC_WRITE,
  output logic        IFID_WRITE,
  output logic        IFID_FLUSH,
  output logic        IDEX_FLUSH,
  output logic        IDEX_HOLD,
  output logic        EXMEM_BUBBLE,
  output logic        busy,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic {
    RUN    = 1'b0,
    MDWAIT = 1'b1
  } state_t;

  // md_cnt is loaded with the number of MDWAIT cycles that follow the start cycle.
  localparam logic [3:0] MD_LOAD  = 4'(MULDIV_CYCLES - 2);
  localparam logic       MD_MULTI = (MULDIV_CYCLES > 2);

  state_t     state, state_nxt;
  logic [3:0] md_cnt, md_cnt_nxt;
  logic       md_start;
  logic       load_use;
  logic       flush_evt;

  assign md_start = (IDEX_opcode == MULDIV_OPCODE);
  // Register 0 is compared like any other register on purpose.
  assign load_use = IDEX_MemRead && ((IDEX_RT == IFID_RS) || (IDEX_RT == IFID_RT));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= RUN;
      md_cnt <= 4'd0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    md_cnt_nxt   = md_cnt;
    flush_evt    = 1'b0;
    PC_WRITE     = 1'b1;
    IFID_WRITE   = 1'b1;
    IFID_FLUSH   = 1'b0;
    IDEX_FLUSH   = 1'b0;
    IDEX_HOLD    = 1'b0;
    EXMEM_BUBBLE = 1'b0;
    busy         = 1'b0;

    if (!rst) begin
      // Freeze the front end and keep both buffers empty while in reset.
      PC_WRITE   = 1'b0;
      IFID_WRITE = 1'b0;
      IFID_FLUSH = 1'b1;
      IDEX_FLUSH = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (branch_taken) begin
            // Squash both wrong-path instructions; the front end keeps going.
            IFID_FLUSH = 1'b1;
            IDEX_FLUSH = 1'b1;
            flush_evt  = 1'b1;
          end else if (md_start) begin
            PC_WRITE     = 1'b0;
            IFID_WRITE   = 1'b0;
            IDEX_HOLD    = 1'b1;
            EXMEM_BUBBLE = 1'b1;
            busy         = 1'b1;
            md_cnt_nxt   = MD_LOAD;
            state_nxt    = MD_MULTI ? MDWAIT : RUN;
          end else if (load_use) begin
            // One bubble: the load moves to MEM, the consumer waits in ID.
            PC_WRITE   = 1'b0;
            IFID_WRITE = 1'b0;
            IDEX_FLUSH = 1'b1;
          end
        end
        MDWAIT: begin
          // EX is owned by the mul/div; branch and hazard inputs are not acted on.
          PC_WRITE     = 1'b0;
          IFID_WRITE   = 1'b0;
          IDEX_HOLD    = 1'b1;
          EXMEM_BUBBLE = 1'b1;
          busy         = 1'b1;
          md_cnt_nxt   = md_cnt - 4'd1;
          // md_cnt==0 cannot occur here; leaving on it avoids a wrap-around lockup.
          if (md_cnt <= 4'd1) begin
            state_nxt  = RUN;
            md_cnt_nxt = 4'd0;
          end
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || clr_cnt) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (!PC_WRITE && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (flush_evt && (flush_cnt != 16'hFFFF)) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard controller for the 16-bit, 4-stage-front pipeline. It sequences the IF/ID and ID/EX pipeline buffers and generates the following controls:
- PC-write enable, IF/ID write enable, IF/ID flush and ID/EX flush.
- An ID/EX hold and an EX/MEM bubble for multi-cycle multiply/divide.

It resolves load-use stalls, taken-branch flushes and multi-cycle EX occupancy. It also keeps saturating stall/flush performance counters. It sits beside the control unit and drives the flush/hold inputs of the stage buffers directly.

## Interface
Parameters:
- MULDIV_CYCLES, 4, total EX cycles of a multiply/divide instruction; legal range 2..15.
- MULDIV_OPCODE, 4'hE, EX-stage opcode that identifies a multiply/divide.

Ports (clock is clk; reset is rst, synchronous, active-low):
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-low reset
- IDEX_MemRead  in  1  instruction in EX is a load
- IDEX_RT  in  4  destination register of instruction in EX
- IDEX_opcode  in  4  opcode of instruction in EX
- IFID_RS, IFID_RT  in  4 each  source registers of instruction in ID
- branch_taken  in  1  branch in EX resolved taken this cycle
- clr_cnt  in  1  synchronous clear of performance counters
- PC_WRITE  out  1  1 = PC loads next value
- IFID_WRITE  out  1  1 = IF/ID buffer captures
- IFID_FLUSH  out  1  1 = IF/ID buffer loads NOP
- IDEX_FLUSH  out  1  1 = ID/EX buffer loads all-zero controls (bubble)
- IDEX_HOLD  out  1  1 = ID/EX buffer retains contents
- EXMEM_BUBBLE  out  1  1 = EX/MEM buffer loads zero controls
- busy  out  1  1 = multi-cycle sequence in progress
- stall_cnt  out  16  cycles with PC_WRITE=0, saturating
- flush_cnt  out  16  taken-branch flush events, saturating

## Operation
- States: RUN, MDWAIT. Internal 4-bit down-counter md_cnt.
- Outputs are Mealy. They are a function of the current state and the current inputs. State and counters are registered.
- Default output set: PC_WRITE=1, IFID_WRITE=1, and all other control outputs 0.
- While rst=0, outputs are PC_WRITE=0, IFID_WRITE=0, IFID_FLUSH=1, IDEX_FLUSH=1, IDEX_HOLD=0, EXMEM_BUBBLE=0, busy=0.
- On the reset edge: state=RUN, md_cnt=0, stall_cnt=0, flush_cnt=0.
- RUN, conditions evaluated in priority order:
  1. branch_taken: IFID_FLUSH=1, IDEX_FLUSH=1. flush_cnt increments. Next state RUN.
  2. md_start (IDEX_opcode==MULDIV_OPCODE): PC_WRITE=0, IFID_WRITE=0, IDEX_HOLD=1, EXMEM_BUBBLE=1, busy=1. md_cnt<=MULDIV_CYCLES-2. Next state is MDWAIT if MULDIV_CYCLES>2, otherwise RUN.
  3. Load-use (IDEX_MemRead=1 and IDEX_RT equals IFID_RS or IFID_RT): PC_WRITE=0, IFID_WRITE=0, IDEX_FLUSH=1. Next state RUN. This is exactly one bubble.
  4. Otherwise: default output set.
- MDWAIT:
  - Outputs: PC_WRITE=0, IFID_WRITE=0, IDEX_HOLD=1, EXMEM_BUBBLE=1, busy=1.
  - md_cnt decrements each cycle. When md_cnt==1, next state is RUN.
  - branch_taken, md_start and load-use inputs are ignored, because EX holds the multiply/divide.
- The first RUN cycle after MDWAIT releases the hold. The held multiply/divide then moves to MEM. md_start is not re-triggered, because the EX opcode changes on that edge.
- Load-use is detected against register 0 as well; no special-casing.
- Counters:
  - stall_cnt increments on every cycle with rst=1 and PC_WRITE=0.
  - Both counters saturate at 16'hFFFF.
  - clr_cnt=1 zeroes both counters and has priority over increment.

## Timing
- All controls take effect in the same cycle as the detecting inputs (zero latency). Buffers act on the next edge.
- Load-use costs 1 stall cycle.
- A taken branch costs 2 squashed instructions (IF/ID and ID/EX) and 0 stall cycles.
- A multiply/divide stalls the front end for MULDIV_CYCLES-1 cycles: the md_start cycle plus MULDIV_CYCLES-2 MDWAIT cycles.
- busy=1 for exactly those cycles.
- Reset asserted mid-MDWAIT aborts the sequence on that edge; the held instruction is lost.
- Outputs must be glitch-tolerant only at the clock edge. There are no registered-output requirements.

## Test plan
- Reset held 3 cycles then released, no hazards -> during reset PC_WRITE=0, IFID_FLUSH=1, IDEX_FLUSH=1; afterwards PC_WRITE=1, IFID_WRITE=1, all others 0, counters 0.
- IDEX_MemRead=1, IDEX_RT=4'h3, IFID_RT=4'h3 for one cycle -> exactly 1 cycle of PC_WRITE=0, IDEX_FLUSH=1; stall_cnt=1.
- branch_taken=1 together with load-use match -> IFID_FLUSH=1, IDEX_FLUSH=1, PC_WRITE=1; flush_cnt=1, stall_cnt unchanged.
- IDEX_opcode=4'hE held while IDEX_HOLD=1, with MULDIV_CYCLES=4 -> busy/IDEX_HOLD/EXMEM_BUBBLE high for exactly 3 cycles and stall_cnt=3; branch_taken pulsed mid-sequence is ignored (flush_cnt unchanged).
- MULDIV_CYCLES=2 -> single-cycle stall, no MDWAIT entry. Separately, rst=0 asserted in the 2nd MDWAIT cycle (MULDIV_CYCLES=4) -> state RUN and counters 0 after the edge.
- Force stall_cnt to 16'hFFFF via 65535 stall cycles, then stall again -> stays 16'hFFFF; clr_cnt=1 concurrent with a stall -> 0.
